spi_cmd_controller: RTL
=======================

Name: spi_cmd_controller

Overview:
- Command/sequencing layer behind the SPI byte-level slave.
- Decodes the byte stream of each chip-select frame as opcode, address, then a data burst.
- Drives a simple synchronous register-file bus with auto-incrementing address.
- Supplies the byte the SPI slave shifts out on MISO, including a status byte during the opcode and read data during read bursts.

Parameters:
ADDR_W, 8, register address width; address wraps modulo 2^ADDR_W.
STATUS_ID, 4'hA, constant upper nibble of the status byte.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse when chip select asserts
frame_end  in  1  one-cycle pulse when chip select deasserts
rx_valid  in  1  one-cycle pulse, complete byte received
rx_byte  in  8  received byte, valid with rx_valid
tx_byte  out  8  next byte for the SPI slave to shift out
tx_load  out  1  one-cycle pulse, slave loads tx_byte into its shift register
reg_addr  out  ADDR_W  register bus address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
busy  out  1  high while state != IDLE
cmd_err  out  1  sticky: undefined opcode received
seq_err  out  1  sticky: framing violation

Behaviour:
- Reset:
  - State IDLE.
  - tx_byte=0x00; tx_load, reg_we, reg_re=0.
  - reg_addr=0, reg_wdata=0.
  - busy, cmd_err, seq_err=0.
  - Internal address and pending-fetch flags cleared.
  - rst has priority over all inputs in the same cycle.
- States: IDLE, CMD, ADDR, WDATA, RDATA, DRAIN.
- Status byte = {STATUS_ID, 2'b00, seq_err, cmd_err}.
- IDLE:
  - frame_start -> CMD; same cycle: tx_byte<=status, tx_load=1.
  - rx_valid in IDLE -> seq_err<=1, byte ignored.
- CMD, on rx_valid:
  - 0x01 -> ADDR (write).
  - 0x02 -> ADDR (read).
  - 0x00 -> DRAIN (NOP).
  - 0x03 -> cmd_err<=0, seq_err<=0, DRAIN.
  - Any other value -> cmd_err<=1, DRAIN.
  - Every case also: tx_byte<=0x00, tx_load=1.
- ADDR, on rx_valid: internal addr<=rx_byte[ADDR_W-1:0].
  - Write: -> WDATA, tx_byte<=0x00, tx_load=1 the same cycle.
  - Read: -> RDATA and start a fetch.
- Fetch sequence, with rx_valid at cycle T:
  - T+1: reg_re=1, reg_addr=addr.
  - T+2: tx_byte<=reg_rdata, tx_load=1, addr<=addr+1.
  - Fetch latency is 2 cycles. Integration constraint: SCK half-period >= 4 clk.
- RDATA: each rx_valid (dummy byte from master) starts a fetch at the current addr.
  - The first read byte is therefore shifted out during the byte after the address byte.
- WDATA, on each rx_valid at T:
  - T+1: reg_we=1, reg_addr=addr, reg_wdata=rx_byte.
  - addr<=addr+1 at the same time.
  - tx_byte<=0x00, tx_load=1 at T+1.
- DRAIN: rx_valid bytes ignored; each reloads tx_byte=0x00 with tx_load=1.
- Address wrap: addr 2^ADDR_W-1 increments to 0; no error.
- frame_end, any state:
  - -> IDLE next cycle.
  - Any pending fetch or write stage issued at the same edge still completes its reg_re/reg_we.
  - No tx_load after frame_end.
  - No new reg_we/reg_re is issued for later bytes.
- Simultaneous events:
  - rx_valid and frame_end in the same cycle: byte processed (write still issued at T+1), then IDLE.
  - frame_start while not IDLE (missed frame_end): seq_err<=1, restart in CMD with status load; any in-flight fetch is discarded (its tx_load is suppressed).
  - frame_start and rx_valid in the same cycle: frame_start wins, byte dropped, seq_err<=1.
- Strobes: reg_we and reg_re are never high together and are each exactly one cycle wide.
- busy=1 for every state except IDLE.

Test Plan:
- Write burst:
  - Stimulus: reset, then frame 01,10,AA,BB,CC, end.
  - Expected: reg_we pulses at addr 0x10/0x11/0x12 with AA/BB/CC; first tx_load carries 0xA0; busy falls after frame_end.
- Read burst:
  - Stimulus: regfile preloaded 0x20=5A, 0x21=C3; frame 02,20,xx,xx.
  - Expected: reg_re at 0x20 then 0x21; tx_load carries 5A two cycles after the address byte's rx_valid and C3 two cycles after the first dummy byte's rx_valid.
- Wrap:
  - Stimulus: write frame 01,FF,11,22.
  - Expected: writes 0xFF<=11 and 0x00<=22; no error flags.
- Bad opcode:
  - Stimulus: frame 7E,55, end.
  - Expected: cmd_err=1, no reg_we/reg_re.
  - Follow-up: next frame's status byte = 0xA1; frame 03 clears it, and the following frame's status byte = 0xA0.
- Framing errors:
  - Stimulus: rx_valid in IDLE. Expected: seq_err=1.
  - Stimulus: second frame_start mid-read-burst, one cycle after the reg_re. Expected: no tx_load of that fetched data; restart in CMD with status 0xA2 loaded.
- Reset mid-burst:
  - Stimulus: rst during WDATA.
  - Expected: all outputs return to reset values in the next cycle; subsequent bytes are ignored until a new frame_start.

Source files
------------

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller
//   Command/sequencing layer behind an SPI byte-level slave. Each chip-select
//   frame is decoded as opcode, address, then a data burst that drives a simple
//   synchronous register-file bus with an auto-incrementing address.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   frame_start/end      one-cycle pulses on chip-select assert/deassert
//   rx_valid, rx_byte    received byte strobe and value
//   tx_byte, tx_load     byte for the slave to shift out next, load strobe
//   reg_addr/wdata/we/re register-file bus (reg_rdata valid 1 cycle after reg_re)
//   busy                 high whenever a frame is being decoded
//   cmd_err, seq_err     sticky error flags (undefined opcode, framing violation)
module spi_cmd_controller #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [3:0]  STATUS_ID = 4'hA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              cmd_err,
    output logic              seq_err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StDrain} state_e;

    state_e            state_q;
    logic              is_read_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_q;
    logic              ld_q;
    logic              fetch_wait_q;   // reg_rdata arrives this cycle
    logic              fetch_ld;
    logic              seq_err_d;
    logic [7:0]        status_d;

    always_comb begin
        // A completing fetch is dropped if the frame ends or restarts this cycle.
        fetch_ld  = fetch_wait_q & ~rst & ~frame_start & ~frame_end;
        // Status loaded on frame_start must already show a violation flagged now.
        seq_err_d = seq_err | (frame_start & (rx_valid | (state_q != StIdle)));
        status_d  = {STATUS_ID, 2'b00, seq_err_d, cmd_err};
        // Read data is forwarded straight from the bus so it is loaded with a
        // 2-cycle latency; tx_q captures it at the same edge to hold the value.
        tx_byte   = fetch_ld ? reg_rdata : tx_q;
        tx_load   = ld_q | fetch_ld;
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            tx_q         <= 8'h00;
            ld_q         <= 1'b0;
            fetch_wait_q <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= 8'h00;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            cmd_err      <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            ld_q         <= 1'b0;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            fetch_wait_q <= reg_re && (state_q == StRdata) && !frame_start && !frame_end;
            if (fetch_ld) begin
                tx_q <= reg_rdata;
            end

            if (frame_start) begin
                // Restart wins over everything, including a byte this cycle.
                state_q <= StCmd;
                seq_err <= seq_err_d;
                tx_q    <= status_d;
                ld_q    <= 1'b1;
            end else begin
                if (rx_valid) begin
                    unique case (state_q)
                        StIdle: seq_err <= 1'b1;
                        StCmd: begin
                            tx_q <= 8'h00;
                            ld_q <= 1'b1;
                            case (rx_byte)
                                8'h01: begin
                                    is_read_q <= 1'b0;
                                    state_q   <= StAddr;
                                end
                                8'h02: begin
                                    is_read_q <= 1'b1;
                                    state_q   <= StAddr;
                                end
                                8'h00: state_q <= StDrain;
                                8'h03: begin
                                    cmd_err <= 1'b0;
                                    seq_err <= 1'b0;
                                    state_q <= StDrain;
                                end
                                default: begin
                                    cmd_err <= 1'b1;
                                    state_q <= StDrain;
                                end
                            endcase
                        end
                        StAddr: begin
                            if (is_read_q) begin
                                reg_re   <= 1'b1;
                                reg_addr <= rx_byte[ADDR_W-1:0];
                                addr_q   <= rx_byte[ADDR_W-1:0] + ADDR_ONE;
                                state_q  <= StRdata;
                            end else begin
                                addr_q  <= rx_byte[ADDR_W-1:0];
                                tx_q    <= 8'h00;
                                ld_q    <= 1'b1;
                                state_q <= StWdata;
                            end
                        end
                        StWdata: begin
                            reg_we    <= 1'b1;
                            reg_addr  <= addr_q;
                            reg_wdata <= rx_byte;
                            addr_q    <= addr_q + ADDR_ONE;
                            tx_q      <= 8'h00;
                            ld_q      <= 1'b1;
                        end
                        StRdata: begin
                            reg_re   <= 1'b1;
                            reg_addr <= addr_q;
                            addr_q   <= addr_q + ADDR_ONE;
                        end
                        StDrain: begin
                            tx_q <= 8'h00;
                            ld_q <= 1'b1;
                        end
                        default: state_q <= StIdle;
                    endcase
                end
                // Strobes issued above still go out; only the load is withheld.
                if (frame_end) begin
                    state_q <= StIdle;
                    ld_q    <= 1'b0;
                end
            end
        end
    end

endmodule
